// File: rtl/issue_pkg.sv
// issue_pkg: shared widths, state encoding and helpers for the issue stage.
// Optional: ISSUE_STALL_CNT_EN enables the saturating stall counter.
`default_nettype none

package issue_pkg;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_REG_WIDTH = 4;
  localparam int DEF_OP_WIDTH  = 6;
  localparam int STALL_CNT_W   = 32;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } issue_state_e;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_stage_if.sv
// issue_stage_if: decode->issue and issue->execute valid/ready channels.
// master drives the payload and valid, slave drives ready.
`default_nettype none

interface issue_id_if
  import issue_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH
);
  logic                 valid;
  logic                 ready;
  logic [OP_WIDTH-1:0]  op;
  logic [REG_WIDTH-1:0] dr;
  logic [REG_WIDTH-1:0] sr1;
  logic [REG_WIDTH-1:0] sr2;
  logic                 use1;
  logic                 use2;
  logic                 wr;
  logic [BIT_WIDTH-1:0] imm;

  modport master (output valid, op, dr, sr1, sr2, use1, use2, wr, imm, input ready);
  modport slave  (input valid, op, dr, sr1, sr2, use1, use2, wr, imm, output ready);
endinterface

interface issue_ex_if
  import issue_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH
);
  logic                 valid;
  logic                 ready;
  logic [OP_WIDTH-1:0]  op;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic [BIT_WIDTH-1:0] imm;
  logic [REG_WIDTH-1:0] dr;
  logic                 wr;

  modport master (output valid, op, a, b, imm, dr, wr, input ready);
  modport slave  (input valid, op, a, b, imm, dr, wr, output ready);
endinterface

`default_nettype wire

// File: rtl/operand_select.sv
// operand_select: per-source RAW hazard detection and forward/regfile operand mux.
`default_nettype none

module operand_select
  import issue_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 use_src,
  input  logic                 busy,
  input  logic                 fwd,
  input  logic [BIT_WIDTH-1:0] val,
  input  logic [BIT_WIDTH-1:0] wb_data,
  output logic                 hazard,
  output logic [BIT_WIDTH-1:0] operand
);

  // A forwarded value resolves the hazard even though the busy bit is still set.
  assign hazard  = use_src & busy & ~fwd;
  assign operand = fwd ? wb_data : val;

endmodule

`default_nettype wire

// File: rtl/issue_stage.sv
// issue_stage: RAW-stalling issue stage with a one-entry execute register.
// Optional: ISSUE_STALL_CNT_EN adds a saturating stall_cnt output.
`default_nettype none

module issue_stage
  import issue_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  issue_id_if.slave              id,
  output logic [REG_WIDTH-1:0]   rf_sr1,
  output logic [REG_WIDTH-1:0]   rf_sr2,
  input  logic [BIT_WIDTH-1:0]   rf_val1,
  input  logic [BIT_WIDTH-1:0]   rf_val2,
  input  logic                   rf_busy1,
  input  logic                   rf_busy2,
  input  logic                   rf_fwd1,
  input  logic                   rf_fwd2,
  input  logic [BIT_WIDTH-1:0]   wb_data,
  output logic                   rf_wrtEn,
  output logic [REG_WIDTH-1:0]   rf_wrtR,
  output logic                   rf_busyClr,
  input  logic                   flush,
`ifdef ISSUE_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  issue_ex_if.master             ex
);

  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_FULL  = FULL;

  logic [0:0]           r_state;
  logic [OP_WIDTH-1:0]  r_op;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;
  logic [BIT_WIDTH-1:0] r_imm;
  logic [REG_WIDTH-1:0] r_dr;
  logic                 r_wr;

  logic                 w_haz1;
  logic                 w_haz2;
  logic [BIT_WIDTH-1:0] w_opnd1;
  logic [BIT_WIDTH-1:0] w_opnd2;
  logic                 w_space;
  logic                 w_id_ready;
  logic                 w_fire;
  logic                 w_drop_clr;

  operand_select #(.BIT_WIDTH(BIT_WIDTH)) u_src1 (
    .use_src (id.use1),
    .busy    (rf_busy1),
    .fwd     (rf_fwd1),
    .val     (rf_val1),
    .wb_data (wb_data),
    .hazard  (w_haz1),
    .operand (w_opnd1)
  );

  operand_select #(.BIT_WIDTH(BIT_WIDTH)) u_src2 (
    .use_src (id.use2),
    .busy    (rf_busy2),
    .fwd     (rf_fwd2),
    .val     (rf_val2),
    .wb_data (wb_data),
    .hazard  (w_haz2),
    .operand (w_opnd2)
  );

  assign rf_sr1 = id.sr1;
  assign rf_sr2 = id.sr2;

  assign w_space    = (r_state == ST_EMPTY) | ex.ready;
  assign w_id_ready = rst & ~flush & w_space & ~w_haz1 & ~w_haz2;
  assign w_fire     = id.valid & w_id_ready;
  assign id.ready   = w_id_ready;

  // A held writer killed before execute took it must release its busy bit.
  assign w_drop_clr = rst & flush & (r_state == ST_FULL) & r_wr & ~ex.ready;

  always_comb begin
    rf_wrtEn   = 1'b0;
    rf_wrtR    = '0;
    rf_busyClr = 1'b0;
    if (w_drop_clr) begin
      rf_wrtEn   = 1'b1;
      rf_wrtR    = r_dr;
      rf_busyClr = 1'b1;
    end else if (w_fire & id.wr) begin
      rf_wrtEn   = 1'b1;
      rf_wrtR    = id.dr;
      rf_busyClr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_dr    <= '0;
      r_wr    <= 1'b0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else if (w_fire) begin
      r_state <= ST_FULL;
      r_op    <= id.op;
      r_a     <= w_opnd1;
      r_b     <= w_opnd2;
      r_imm   <= id.imm;
      r_dr    <= id.dr;
      r_wr    <= id.wr;
    end else if (ex.ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign ex.valid = (r_state == ST_FULL);
  assign ex.op    = r_op;
  assign ex.a     = r_a;
  assign ex.b     = r_b;
  assign ex.imm   = r_imm;
  assign ex.dr    = r_dr;
  assign ex.wr    = r_wr;

`ifdef ISSUE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (id.valid & ~w_id_ready & ~flush) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed plus random stimulus against a rule-level model of the issue stage.
`default_nettype none

module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rf_sr1, rf_sr2, rf_wrtR;
  logic [31:0] rf_val1, rf_val2, wb_data;
  logic        rf_busy1, rf_busy2, rf_fwd1, rf_fwd2;
  logic        rf_wrtEn, rf_busyClr, flush;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  issue_id_if id_bus ();
  issue_ex_if ex_bus ();

  issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .id         (id_bus),
    .rf_sr1     (rf_sr1),
    .rf_sr2     (rf_sr2),
    .rf_val1    (rf_val1),
    .rf_val2    (rf_val2),
    .rf_busy1   (rf_busy1),
    .rf_busy2   (rf_busy2),
    .rf_fwd1    (rf_fwd1),
    .rf_fwd2    (rf_fwd2),
    .wb_data    (wb_data),
    .rf_wrtEn   (rf_wrtEn),
    .rf_wrtR    (rf_wrtR),
    .rf_busyClr (rf_busyClr),
    .flush      (flush),
`ifdef ISSUE_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .ex         (ex_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the execute register: what execute should currently see.
  logic        m_valid;
  logic [5:0]  m_op;
  logic [31:0] m_a, m_b, m_imm;
  logic [3:0]  m_dr;
  logic        m_wr;
  longint      m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    logic        h1, h2, exp_rdy, fire, exp_en, exp_clr;
    logic [3:0]  exp_r;
    logic [31:0] o1, o2;
    #2;
    h1 = id_bus.use1 && rf_busy1 && !rf_fwd1;
    h2 = id_bus.use2 && rf_busy2 && !rf_fwd2;
    o1 = rf_fwd1 ? wb_data : rf_val1;
    o2 = rf_fwd2 ? wb_data : rf_val2;
    exp_rdy = rst && !flush && (!m_valid || ex_bus.ready) && !h1 && !h2;
    fire = id_bus.valid && exp_rdy;
    exp_en = 1'b0; exp_clr = 1'b0; exp_r = 4'd0;
    if (rst && flush && m_valid && m_wr && !ex_bus.ready) begin
      exp_en = 1'b1; exp_clr = 1'b1; exp_r = m_dr;
    end else if (fire && id_bus.wr) begin
      exp_en = 1'b1; exp_r = id_bus.dr;
    end
    chk({tag, ".id_ready"}, 32'(id_bus.ready), 32'(exp_rdy));
    chk({tag, ".rf_sr1"}, 32'(rf_sr1), 32'(id_bus.sr1));
    chk({tag, ".rf_sr2"}, 32'(rf_sr2), 32'(id_bus.sr2));
    chk({tag, ".rf_wrtEn"}, 32'(rf_wrtEn), 32'(exp_en));
    if (exp_en) begin
      chk({tag, ".rf_wrtR"}, 32'(rf_wrtR), 32'(exp_r));
      chk({tag, ".rf_busyClr"}, 32'(rf_busyClr), 32'(exp_clr));
    end
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0; m_dr = '0; m_wr = 1'b0;
      m_stall = 0;
    end else begin
      if (id_bus.valid && !exp_rdy && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) m_valid = 1'b0;
      else if (fire) begin
        m_valid = 1'b1; m_op = id_bus.op; m_a = o1; m_b = o2;
        m_imm = id_bus.imm; m_dr = id_bus.dr; m_wr = id_bus.wr;
      end else if (ex_bus.ready) m_valid = 1'b0;
    end
    #1;
    chk({tag, ".ex_valid"}, 32'(ex_bus.valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".ex_op"}, 32'(ex_bus.op), 32'(m_op));
      chk({tag, ".ex_a"}, ex_bus.a, m_a);
      chk({tag, ".ex_b"}, ex_bus.b, m_b);
      chk({tag, ".ex_imm"}, ex_bus.imm, m_imm);
      chk({tag, ".ex_dr"}, 32'(ex_bus.dr), 32'(m_dr));
      chk({tag, ".ex_wr"}, 32'(ex_bus.wr), 32'(m_wr));
    end
`ifdef ISSUE_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, 32'(m_stall));
`endif
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [3:0] dr, input logic [3:0] s1,
                           input logic [3:0] s2, input logic wr, input logic [31:0] imm);
    id_bus.valid = 1'b1; id_bus.op = op; id_bus.dr = dr; id_bus.sr1 = s1; id_bus.sr2 = s2;
    id_bus.use1 = 1'b1; id_bus.use2 = 1'b1; id_bus.wr = wr; id_bus.imm = imm;
  endtask

  initial begin
    m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0; m_dr = '0; m_wr = 1'b0;
    m_stall = 0;
    rst = 1'b0; flush = 1'b0; ex_bus.ready = 1'b1;
    rf_val1 = 32'h11; rf_val2 = 32'h22; wb_data = 32'h0;
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_fwd1 = 1'b0; rf_fwd2 = 1'b0;
    set_instr(6'd1, 4'd5, 4'd3, 4'd4, 1'b1, 32'h100);

    // Reset held for two edges with a pending instruction.
    step("rst0");
    step("rst1");
    chk("rst.ex_valid", 32'(ex_bus.valid), 32'd0);
    chk("rst.ex_op", 32'(ex_bus.op), 32'd0);
    chk("rst.ex_a", ex_bus.a, 32'd0);
    chk("rst.ex_dr", 32'(ex_bus.dr), 32'd0);
    chk("rst.ex_wr", 32'(ex_bus.wr), 32'd0);

    // First edge after release issues the plain instruction.
    rst = 1'b1;
    step("issue");
    chk("issue.ex_a", ex_bus.a, 32'h11);
    chk("issue.ex_b", ex_bus.b, 32'h22);
    chk("issue.ex_dr", 32'(ex_bus.dr), 32'd5);

    // RAW hazard on source 1 for three cycles; held entry drains meanwhile.
    set_instr(6'd2, 4'd6, 4'd5, 4'd4, 1'b1, 32'h200);
    rf_busy1 = 1'b1; rf_fwd1 = 1'b0;
    for (int i = 0; i < 3; i++) step("raw");
    chk("raw.ex_valid", 32'(ex_bus.valid), 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    chk("raw.stall_cnt3", stall_cnt, 32'd3);
`endif

    // Same-cycle forward resolves the hazard.
    rf_fwd1 = 1'b1; wb_data = 32'hDEAD_BEEF;
    step("fwd");
    chk("fwd.ex_a", ex_bus.a, 32'hDEAD_BEEF);
    rf_busy1 = 1'b0; rf_fwd1 = 1'b0;

    // Backpressure: held entry must stay put, then reload back-to-back.
    set_instr(6'd3, 4'd8, 4'd1, 4'd2, 1'b1, 32'h300);
    rf_val1 = 32'h33; rf_val2 = 32'h44; ex_bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) step("bp");
    chk("bp.ex_dr_held", 32'(ex_bus.dr), 32'd6);
    ex_bus.ready = 1'b1;
    step("bp_reload");
    chk("bp.ex_dr_new", 32'(ex_bus.dr), 32'd8);

    // Flush of an un-consumed writer releases its busy bit.
    set_instr(6'd4, 4'd7, 4'd9, 4'd10, 1'b1, 32'h400);
    step("fl_load");
    ex_bus.ready = 1'b0; flush = 1'b1;
    set_instr(6'd5, 4'd11, 4'd1, 4'd1, 1'b1, 32'h500);
    #2;
    chk("flush.rf_wrtEn", 32'(rf_wrtEn), 32'd1);
    chk("flush.rf_wrtR", 32'(rf_wrtR), 32'd7);
    chk("flush.rf_busyClr", 32'(rf_busyClr), 32'd1);
    chk("flush.id_ready", 32'(id_bus.ready), 32'd0);
    step("flush");
    chk("flush.ex_valid", 32'(ex_bus.valid), 32'd0);
    flush = 1'b0; ex_bus.ready = 1'b1;

    // Self-dependence: destination equals source, no busy yet.
    set_instr(6'd6, 4'd9, 4'd9, 4'd9, 1'b1, 32'h600);
    step("self");

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_bus.ready = ($urandom_range(0, 2) != 0);
      id_bus.valid = ($urandom_range(0, 3) != 0);
      id_bus.op = 6'($urandom); id_bus.dr = 4'($urandom);
      id_bus.sr1 = 4'($urandom); id_bus.sr2 = 4'($urandom);
      id_bus.use1 = 1'($urandom); id_bus.use2 = 1'($urandom);
      id_bus.wr = 1'($urandom); id_bus.imm = $urandom;
      rf_val1 = $urandom; rf_val2 = $urandom; wb_data = $urandom;
      rf_busy1 = ($urandom_range(0, 2) == 0); rf_busy2 = ($urandom_range(0, 2) == 0);
      rf_fwd1 = ($urandom_range(0, 3) == 0); rf_fwd2 = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
